// File: rtl/lights_monitor_if.sv
// lights_monitor_if: lamp lines from the Lights sequencer plus the decoded status
// returned by the monitor. The master drives the lamps and the slave observes them.
interface lights_monitor_if #(
    parameter int REV_W = 8
);
    logic             up;
    logic             left;
    logic             down;
    logic             right;
    logic [1:0]       dir;
    logic [1:0]       pos;
    logic             valid;
    logic             step;
    logic [REV_W-1:0] rev_cnt;
    logic             stall;
    logic             err;

    modport master (
        output up, left, down, right,
        input  dir, pos, valid, step, rev_cnt, stall, err
    );

    modport slave (
        input  up, left, down, right,
        output dir, pos, valid, step, rev_cnt, stall, err
    );
endinterface

// File: rtl/lights_monitor.sv
// lights_monitor: decodes the rotating-lamp pattern into direction, position,
// revolution count, stall and sticky fault status. All outputs come from registers.
module lights_monitor #(
    parameter int REV_W     = 8,
    parameter int STALL_MAX = 16
) (
    input logic            clk_i,
    input logic            rst_ni,
    lights_monitor_if.slave mon_io
);
    localparam int SW = $clog2(STALL_MAX + 1);
    localparam logic [SW-1:0] STALL_TOP = SW'(STALL_MAX);

    typedef enum logic [2:0] {IDLE, LOCK, LEFT, RIGHT, FAULT} state_e;

    state_e           state_q, state_d;
    logic [3:0]       prev_q;
    logic [REV_W-1:0] rev_q, rev_d;
    logic [1:0]       stepc_q, stepc_d;
    logic [SW-1:0]    stall_q, stall_d;
    logic             step_q, step_d;
    logic [3:0]       smp;
    logic [1:0]       s_pos, p_pos;
    logic             zero, onehot, multi, fwd, bwd, tracking;

    function automatic logic [1:0] enc(input logic [3:0] v);
        return v[3] ? 2'd0 : v[2] ? 2'd1 : v[1] ? 2'd2 : 2'd3;
    endfunction

    assign smp    = {mon_io.up, mon_io.left, mon_io.down, mon_io.right};
    assign zero   = (smp == 4'b0000);
    assign onehot = !zero && ((smp & (smp - 4'd1)) == 4'b0000);
    assign multi  = !zero && !onehot;
    assign s_pos  = enc(smp);
    assign p_pos  = enc(prev_q);
    // Left rotation advances the ring index by one, right rotation retreats by one
    assign fwd    = (s_pos == p_pos + 2'd1);
    assign bwd    = (s_pos == p_pos - 2'd1);

    always_comb begin
        state_d = state_q;
        rev_d   = rev_q;
        stepc_d = stepc_q;
        stall_d = stall_q;
        step_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (multi) begin
                    state_d = FAULT;
                end else if (onehot) begin
                    state_d = LOCK;
                    stall_d = SW'(1);
                end
            end
            FAULT: begin
                if (zero) begin
                    state_d = IDLE;
                    rev_d   = '0;
                    stepc_d = '0;
                    stall_d = '0;
                end
            end
            default: begin
                if (zero) begin
                    state_d = IDLE;
                    rev_d   = '0;
                    stepc_d = '0;
                    stall_d = '0;
                end else if (multi) begin
                    state_d = FAULT;
                end else if (smp == prev_q) begin
                    stall_d = (stall_q == STALL_TOP) ? stall_q : stall_q + SW'(1);
                end else if (fwd || bwd) begin
                    step_d  = 1'b1;
                    stall_d = SW'(1);
                    if ((fwd && state_q == LEFT) || (bwd && state_q == RIGHT)) begin
                        // Two-bit step count wraps to 0 exactly when a revolution completes
                        stepc_d = stepc_q + 2'd1;
                        if (stepc_q == 2'd3) rev_d = &rev_q ? rev_q : rev_q + REV_W'(1);
                    end else begin
                        state_d = fwd ? LEFT : RIGHT;
                        rev_d   = '0;
                        stepc_d = 2'd1;
                    end
                end else begin
                    state_d = FAULT;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            prev_q  <= '0;
            rev_q   <= '0;
            stepc_q <= '0;
            stall_q <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= smp;
            rev_q   <= rev_d;
            stepc_q <= stepc_d;
            stall_q <= stall_d;
            step_q  <= step_d;
        end
    end

    assign tracking       = (state_q inside {LOCK, LEFT, RIGHT});
    assign mon_io.dir     = (state_q == LEFT) ? 2'b01 : (state_q == RIGHT) ? 2'b10 : 2'b00;
    assign mon_io.valid   = tracking;
    assign mon_io.pos     = tracking ? p_pos : 2'd0;
    assign mon_io.step    = step_q;
    assign mon_io.rev_cnt = rev_q;
    assign mon_io.stall   = tracking && (stall_q == STALL_TOP);
    assign mon_io.err     = (state_q == FAULT);
endmodule

// File: tb/tb_lights_monitor.sv
// tb_lights_monitor: directed vector table, hand-written reset/stall/saturation
// sequences and random lamp traffic checked against a behavioural model.
module tb_lights_monitor;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] lamps = 4'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    lights_monitor_if #(.REV_W(8)) bus ();
    lights_monitor_if #(.REV_W(2)) bus2 ();

    assign {bus.up, bus.left, bus.down, bus.right}     = lamps;
    assign {bus2.up, bus2.left, bus2.down, bus2.right} = lamps;

    lights_monitor #(.REV_W(8), .STALL_MAX(16)) dut  (.clk_i(clk), .rst_ni(rst_n), .mon_io(bus));
    lights_monitor #(.REV_W(2), .STALL_MAX(16)) dut2 (.clk_i(clk), .rst_ni(rst_n), .mon_io(bus2));

    typedef struct {
        logic [3:0] s;
        logic [1:0] dir;
        logic [1:0] pos;
        logic       valid;
        logic       step;
        logic [7:0] rev;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model: total steps taken in the current direction and the
    // length of the current run of identical samples, both unbounded.
    bit         m_fault, m_active, m_step;
    int         m_dir, m_steps, m_run;
    logic [3:0] m_prev;

    function automatic vec_t mk(input logic [3:0] s, input int d, input int p, input int v,
                                input int st, input int rv, input int e);
        mk.s = s; mk.dir = 2'(d); mk.pos = 2'(p); mk.valid = 1'(v);
        mk.step = 1'(st); mk.rev = 8'(rv); mk.err = 1'(e);
    endfunction

    function automatic int lp(input logic [3:0] s);
        return s[3] ? 0 : s[2] ? 1 : s[1] ? 2 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset;
        m_fault = 0; m_active = 0; m_step = 0; m_dir = 0; m_steps = 0; m_run = 0; m_prev = 4'b0;
    endtask

    task automatic model_step(input logic [3:0] s);
        int d, n;
        n = $countones(s);
        m_step = 0;
        if (m_fault) begin
            if (n == 0) begin m_fault = 0; m_active = 0; m_dir = 0; m_steps = 0; m_run = 0; end
        end else if (!m_active) begin
            if (n > 1) m_fault = 1;
            else if (n == 1) begin m_active = 1; m_dir = 0; m_steps = 0; m_run = 1; end
        end else if (n == 0) begin
            m_active = 0; m_dir = 0; m_steps = 0; m_run = 0;
        end else if (n > 1) begin
            m_fault = 1;
        end else if (s == m_prev) begin
            m_run++;
        end else begin
            d = (lp(s) - lp(m_prev) + 4) % 4;
            if (d == 2) begin
                m_fault = 1;
            end else begin
                d = (d == 1) ? 1 : -1;
                m_step = 1;
                m_run = 1;
                if (m_dir == d) m_steps++;
                else begin m_dir = d; m_steps = 1; end
            end
        end
        m_prev = s;
    endtask

    task automatic check_model(input string tag);
        bit v;
        int r;
        v = m_active && !m_fault;
        r = m_steps / 4;
        chk({tag, " dir"},   32'(bus.dir), !v ? 0 : (m_dir == 1) ? 1 : (m_dir == -1) ? 2 : 0);
        chk({tag, " pos"},   32'(bus.pos), v ? lp(m_prev) : 0);
        chk({tag, " valid"}, 32'(bus.valid), 32'(v));
        chk({tag, " step"},  32'(bus.step), 32'(m_step));
        chk({tag, " rev"},   32'(bus.rev_cnt), (r > 255) ? 255 : r);
        chk({tag, " rev2"},  32'(bus2.rev_cnt), (r > 3) ? 3 : r);
        chk({tag, " stall"}, 32'(bus.stall), 32'(v && m_run >= 16));
        chk({tag, " err"},   32'(bus.err), 32'(m_fault));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " dir"},   32'(bus.dir), 0);
        chk({tag, " pos"},   32'(bus.pos), 0);
        chk({tag, " valid"}, 32'(bus.valid), 0);
        chk({tag, " step"},  32'(bus.step), 0);
        chk({tag, " rev"},   32'(bus.rev_cnt), 0);
        chk({tag, " rev2"},  32'(bus2.rev_cnt), 0);
        chk({tag, " stall"}, 32'(bus.stall), 0);
        chk({tag, " err"},   32'(bus.err), 0);
    endtask

    task automatic cyc(input logic [3:0] s);
        lamps = s;
        @(posedge clk);
        model_step(s);
        @(negedge clk);
    endtask

    task automatic do_reset;
        lamps = 4'($urandom_range(0, 15));
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        lamps = 4'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         rdir, hold_left, r, p;
        logic [3:0] s;
        string      tag;

        // Left rotation, two revolutions plus a hold
        tbl.push_back(mk(4'b1000, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'b0100, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(4'b0010, 1, 2, 1, 1, 0, 0));
        tbl.push_back(mk(4'b0001, 1, 3, 1, 1, 0, 0));
        tbl.push_back(mk(4'b1000, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(4'b0100, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(4'b0010, 1, 2, 1, 1, 1, 0));
        tbl.push_back(mk(4'b0001, 1, 3, 1, 1, 1, 0));
        tbl.push_back(mk(4'b1000, 1, 0, 1, 1, 2, 0));
        tbl.push_back(mk(4'b1000, 1, 0, 1, 0, 2, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0));
        // Six left steps then reversal
        tbl.push_back(mk(4'b1000, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'b0100, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(4'b0010, 1, 2, 1, 1, 0, 0));
        tbl.push_back(mk(4'b0001, 1, 3, 1, 1, 0, 0));
        tbl.push_back(mk(4'b1000, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(4'b0100, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(4'b0010, 1, 2, 1, 1, 1, 0));
        tbl.push_back(mk(4'b0100, 2, 1, 1, 1, 0, 0));
        tbl.push_back(mk(4'b1000, 2, 0, 1, 1, 0, 0));
        tbl.push_back(mk(4'b0001, 2, 3, 1, 1, 0, 0));
        tbl.push_back(mk(4'b0010, 2, 2, 1, 1, 1, 0));
        // Multi-bit fault while rotating, sticky until a zero sample
        tbl.push_back(mk(4'b0101, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(4'b0101, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(4'b1000, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0));
        // Skip fault
        tbl.push_back(mk(4'b1000, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(4'b0010, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0));
        // Multi from idle
        tbl.push_back(mk(4'b1100, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0));
        // Lock on Right, right step, then reverse
        tbl.push_back(mk(4'b0001, 0, 3, 1, 0, 0, 0));
        tbl.push_back(mk(4'b0010, 2, 2, 1, 1, 0, 0));
        tbl.push_back(mk(4'b0001, 1, 3, 1, 1, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0));

        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0000);
            check_zero($sformatf("idle%0d", i));
        end

        foreach (tbl[i]) begin
            cyc(tbl[i].s);
            tag = $sformatf("vec%0d", i);
            chk({tag, " dir"},   32'(bus.dir), 32'(tbl[i].dir));
            chk({tag, " pos"},   32'(bus.pos), 32'(tbl[i].pos));
            chk({tag, " valid"}, 32'(bus.valid), 32'(tbl[i].valid));
            chk({tag, " step"},  32'(bus.step), 32'(tbl[i].step));
            chk({tag, " rev"},   32'(bus.rev_cnt), 32'(tbl[i].rev));
            chk({tag, " err"},   32'(bus.err), 32'(tbl[i].err));
            chk({tag, " stall"}, 32'(bus.stall), 0);
        end

        // Stall rises exactly after the 16th identical sample
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            cyc(4'b0100);
            chk($sformatf("stall hold%0d", i), 32'(bus.stall), 32'(i >= 16));
        end
        cyc(4'b0010);
        chk("stall after step", 32'(bus.stall), 0);
        chk("stall step pulse", 32'(bus.step), 1);
        chk("stall step dir", 32'(bus.dir), 1);
        for (int i = 0; i < 16; i++) cyc(4'b0010);
        chk("stall again", 32'(bus.stall), 1);
        cyc(4'b0000);
        chk("stall after zero", 32'(bus.stall), 0);

        // Asynchronous reset in mid-cycle, then resume and saturate the narrow counter
        do_reset();
        cyc(4'b1000);
        cyc(4'b0100);
        cyc(4'b0010);
        cyc(4'b0001);
        chk("pre-async step", 32'(bus.step), 1);
        chk("pre-async dir", 32'(bus.dir), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b0010);
        chk("resume valid", 32'(bus.valid), 1);
        chk("resume step", 32'(bus.step), 0);
        chk("resume dir", 32'(bus.dir), 0);
        chk("resume pos", 32'(bus.pos), 2);
        chk("resume rev", 32'(bus.rev_cnt), 0);
        for (int k = 1; k <= 20; k++) begin
            cyc(4'b1000 >> ((2 + k) % 4));
            check_model($sformatf("sat%0d", k));
        end
        chk("sat rev8", 32'(bus.rev_cnt), 5);
        chk("sat rev2", 32'(bus2.rev_cnt), 3);
        chk("sat step", 32'(bus2.step), 1);

        // Random traffic against the model
        do_reset();
        rdir = 1;
        hold_left = 0;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            p = lp(lamps);
            if ($urandom_range(0, 9) == 0) rdir = -rdir;
            if (hold_left > 0) begin
                s = lamps;
                hold_left--;
            end else if (r < 2) begin
                s = lamps;
                hold_left = int'($urandom_range(12, 20));
            end else if ($countones(lamps) != 1) begin
                s = (r < 50) ? 4'b1000 >> $urandom_range(0, 3) :
                    (r < 85) ? 4'b0000 : 4'($urandom_range(0, 15));
            end else if (r < 70) begin
                s = 4'b1000 >> ((p + rdir + 4) % 4);
            end else if (r < 80) begin
                s = lamps;
            end else if (r < 87) begin
                s = 4'b0000;
            end else if (r < 92) begin
                s = lamps | (4'b1000 >> ((p + 1 + int'($urandom_range(0, 2))) % 4));
            end else if (r < 95) begin
                s = 4'b1000 >> ((p + 2) % 4);
            end else begin
                s = 4'($urandom_range(0, 15));
            end
            cyc(s);
            check_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
